// File: rtl/cpu_defs.sv
// ---------------------------------------------------------------------------
// cpu_defs: definitions shared by the fetch-stage PC sequencer.
//   CPU_RESET_PC   : PC loaded while reset is asserted
//   CPU_EXC_VECTOR : exception handler entry
//   PCEX_BEQ/JAL   : op encodings understood by the next-PC extension unit
//   pcs_state_t    : pc_sequencer FSM states
//   pc_misaligned  : word-alignment test on the low two PC bits
// ---------------------------------------------------------------------------
package cpu_defs;

    localparam logic [31:0] CPU_RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] CPU_EXC_VECTOR = 32'h0000_4180;

    localparam logic PCEX_BEQ = 1'b0;
    localparam logic PCEX_JAL = 1'b1;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } pcs_state_t;

    function automatic logic pc_misaligned(input logic [1:0] pc_lo);
        return pc_lo != 2'b00;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// ---------------------------------------------------------------------------
// pc_sequencer_if: buses between the PC sequencer and its neighbours.
//   Instruction memory : imem_req_o, imem_addr_o (out), imem_ack_i (in)
//   Next-PC unit       : pcex_op_o, pcex_pc4_o, pcex_imm26_o (out),
//                        pcex_npc_i (in, combinational target)
//   master = sequencer side, slave = memory / next-PC unit side.
// ---------------------------------------------------------------------------
interface pc_sequencer_if;

    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;

    logic        pcex_op_o;
    logic [31:0] pcex_pc4_o;
    logic [25:0] pcex_imm26_o;
    logic [31:0] pcex_npc_i;

    modport master (
        output imem_req_o, imem_addr_o, pcex_op_o, pcex_pc4_o, pcex_imm26_o,
        input  imem_ack_i, pcex_npc_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, pcex_op_o, pcex_pc4_o, pcex_imm26_o,
        output imem_ack_i, pcex_npc_i
    );

endinterface

// File: rtl/redirect_arbiter.sv
// ---------------------------------------------------------------------------
// redirect_arbiter: combinational next-PC priority select.
//   Inputs : exception/eret requests, jr and branch redirects, the pending
//            delay-slot target and the sequential PC.
//   Outputs: next_pc  - PC to load at the next advance
//            redirect - some source other than the fallthrough wants the PC
//            squash   - exception or eret: kill the current word now
// Priority: exception > eret > jr > taken branch > pending > pc+4.
// ---------------------------------------------------------------------------
module redirect_arbiter (
    input  logic        exc_req,
    input  logic [31:0] exc_vector,
    input  logic        eret_req,
    input  logic [31:0] epc,
    input  logic        jr_valid,
    input  logic [31:0] jr_target,
    input  logic        br_valid,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        pend_valid,
    input  logic [31:0] pend_target,
    input  logic [31:0] seq_pc,
    output logic [31:0] next_pc,
    output logic        redirect,
    output logic        squash
);

    always_comb begin
        next_pc  = seq_pc + 32'd4;
        redirect = 1'b1;
        squash   = exc_req || eret_req;
        if (exc_req) begin
            next_pc = exc_vector;
        end else if (eret_req) begin
            next_pc = epc;
        end else if (jr_valid) begin
            next_pc = jr_target;
        end else if (br_valid && br_taken) begin
            next_pc = br_target;
        end else begin
            // Fallthrough paths are not new redirects and must not
            // overwrite the pending target.
            redirect = 1'b0;
            if (pend_valid) begin
                next_pc = pend_target;
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer: fetch-stage program counter controller.
//   clk, reset (async, active-low)
//   stall_i                 : hazard stall, holds the fetched word
//   br_*_i                  : D-stage branch/jump (target via next-PC unit)
//   jr_valid_i/jr_target_i  : register-indirect redirect
//   exc_req_i, eret_req_i, epc_i : exception entry / return
//   bus (master)            : imem request/ack and next-PC unit drive
//   pc_o, fetch_valid_o, adel_o : F-stage PC, word valid, misaligned fetch
// ---------------------------------------------------------------------------
module pc_sequencer
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC   = CPU_RESET_PC,
    parameter logic [31:0] EXC_VECTOR = CPU_EXC_VECTOR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        br_valid_i,
    input  logic        br_taken_i,
    input  logic        br_kind_i,
    input  logic [31:0] br_pc4_i,
    input  logic [25:0] br_imm26_i,
    input  logic        jr_valid_i,
    input  logic [31:0] jr_target_i,
    input  logic        exc_req_i,
    input  logic        eret_req_i,
    input  logic [31:0] epc_i,
    pc_sequencer_if.master bus,
    output logic [31:0] pc_o,
    output logic        fetch_valid_o,
    adel_o
);

    pcs_state_t  state;
    logic [31:0] pc;
    logic [31:0] pend_target;
    logic        pend_valid;
    logic        discard;      // an ack is still owed for a squashed fetch

    logic [31:0] next_pc;
    logic        redirect;
    logic        squash;
    logic        misaligned;
    logic        word_here;    // the word at pc is available this cycle
    logic        advance;

    assign bus.pcex_op_o    = br_kind_i ? PCEX_JAL : PCEX_BEQ;
    assign bus.pcex_pc4_o   = br_pc4_i;
    assign bus.pcex_imm26_o = br_imm26_i;
    assign bus.imem_addr_o  = pc;
    assign pc_o             = pc;

    redirect_arbiter u_arb (
        .exc_req     (exc_req_i),
        .exc_vector  (EXC_VECTOR),
        .eret_req    (eret_req_i),
        .epc         (epc_i),
        .jr_valid    (jr_valid_i),
        .jr_target   (jr_target_i),
        .br_valid    (br_valid_i),
        .br_taken    (br_taken_i),
        .br_target   (bus.pcex_npc_i),
        .pend_valid  (pend_valid),
        .pend_target (pend_target),
        .seq_pc      (pc),
        .next_pc     (next_pc),
        .redirect    (redirect),
        .squash      (squash)
    );

    assign misaligned = pc_misaligned(pc[1:0]);

    // A misaligned PC is never sent to memory; it is delivered as if acked
    // so the D stage can raise the address error.
    always_comb begin
        word_here = 1'b0;
        case (state)
            ST_FETCH: word_here = !discard && (misaligned || bus.imem_ack_i);
            ST_HOLD:  word_here = 1'b1;
            default:  word_here = 1'b0;
        endcase
    end

    assign bus.imem_req_o = (state == ST_FETCH) && !discard && !misaligned;
    assign fetch_valid_o  = word_here && !squash;
    assign adel_o         = fetch_valid_o && misaligned;
    assign advance        = word_here && !stall_i && !squash;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_BOOT;
            pc         <= RESET_PC;
            pend_valid <= 1'b0;
            discard    <= 1'b0;
        end else begin
            case (state)
                ST_BOOT: state <= ST_FETCH;
                default: begin
                    if (squash) begin
                        pc         <= next_pc;
                        pend_valid <= 1'b0;
                        state      <= ST_FETCH;
                        // A request already on the bus (or an earlier
                        // squashed one) still owes us an ack to throw away.
                        discard    <= (state == ST_FETCH) && !bus.imem_ack_i &&
                                      (discard || !misaligned);
                    end else begin
                        if (discard && bus.imem_ack_i) begin
                            discard <= 1'b0;
                        end
                        if (advance) begin
                            pc         <= next_pc;
                            pend_valid <= 1'b0;
                            state      <= ST_FETCH;
                        end else begin
                            // Current word is the delay slot: remember the
                            // redirect until it is consumed.
                            if (redirect) begin
                                pend_valid <= 1'b1;
                            end
                            if (word_here) begin
                                state <= ST_HOLD;
                            end
                        end
                    end
                end
            endcase
        end
    end

    // Target storage is qualified by pend_valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (state != ST_BOOT && !squash && !advance && redirect) begin
            pend_target <= next_pc;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer: directed scenarios followed by randomized traffic checked
// against a behavioural model of the fetch sequencer.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_PC = 32'h0000_4180;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_i, br_valid_i, br_taken_i, br_kind_i;
    logic [31:0] br_pc4_i;
    logic [25:0] br_imm26_i;
    logic        jr_valid_i;
    logic [31:0] jr_target_i;
    logic        exc_req_i, eret_req_i;
    logic [31:0] epc_i;
    logic        ack;
    logic [31:0] pc_o;
    logic        fetch_valid_o, adel_o;

    int checks   = 0;
    int failures = 0;

    pc_sequencer_if bus ();

    // Reference next-PC extension unit: beq adds the sign-extended word
    // offset to PC+4, j/jal splices the 26-bit index into the PC+4 region.
    function automatic logic [31:0] npc_calc(input logic op, input logic [31:0] pc4,
                                             input logic [25:0] imm);
        if (op) return {pc4[31:28], imm, 2'b00};
        return pc4 + {{14{imm[15]}}, imm[15:0], 2'b00};
    endfunction

    assign bus.imem_ack_i = ack;
    assign bus.pcex_npc_i = npc_calc(bus.pcex_op_o, bus.pcex_pc4_o, bus.pcex_imm26_o);

    pc_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .stall_i       (stall_i),
        .br_valid_i    (br_valid_i),
        .br_taken_i    (br_taken_i),
        .br_kind_i     (br_kind_i),
        .br_pc4_i      (br_pc4_i),
        .br_imm26_i    (br_imm26_i),
        .jr_valid_i    (jr_valid_i),
        .jr_target_i   (jr_target_i),
        .exc_req_i     (exc_req_i),
        .eret_req_i    (eret_req_i),
        .epc_i         (epc_i),
        .bus           (bus.master),
        .pc_o          (pc_o),
        .fetch_valid_o (fetch_valid_o),
        .adel_o        (adel_o)
    );

    always #5 clk = ~clk;

    // {pc, req, fetch_valid, adel}
    wire [34:0] obs = {pc_o, bus.imem_req_o, fetch_valid_o, adel_o};

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall_i = 0; br_valid_i = 0; br_taken_i = 0; br_kind_i = 0;
        br_pc4_i = '0; br_imm26_i = '0; jr_valid_i = 0; jr_target_i = '0;
        exc_req_i = 0; eret_req_i = 0; epc_i = '0; ack = 0;
    endtask

    task automatic test_reset();
        reset = 0; idle(); ack = 1;
        @(negedge clk);
        checks++;
        if (obs !== {RST_PC, 3'b000}) begin failures++; $display("FAIL reset_state got=%h exp=%h", obs, {RST_PC, 3'b000}); end
        sync(); reset = 1;                   // late ack still high during BOOT
        @(negedge clk);
        checks++;
        if (obs !== {RST_PC, 3'b000}) begin failures++; $display("FAIL boot_idle got=%h exp=%h", obs, {RST_PC, 3'b000}); end
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 2; i++) begin
            sync(); ack = 1;
            @(negedge clk);
            checks++;
            if (obs !== {RST_PC + 32'(4 * i), 3'b110}) begin failures++; $display("FAIL seq_%0d got=%h exp=%h", i, obs, {RST_PC + 32'(4 * i), 3'b110}); end
        end
    endtask

    task automatic test_branch();
        sync(); ack = 1;
        br_valid_i = 1; br_taken_i = 1; br_kind_i = 0; br_pc4_i = 32'h3008; br_imm26_i = 26'h000FFFE;
        @(negedge clk);
        checks++;
        if (obs !== {32'h3008, 3'b110}) begin failures++; $display("FAIL beq_delay_slot got=%h exp=%h", obs, {32'h3008, 3'b110}); end
        checks++;
        if ({bus.pcex_op_o, bus.pcex_pc4_o, bus.pcex_imm26_o} !== {1'b0, 32'h3008, 26'h000FFFE}) begin
            failures++; $display("FAIL pcex_drive got=%h exp=%h", {bus.pcex_op_o, bus.pcex_pc4_o, bus.pcex_imm26_o}, {1'b0, 32'h3008, 26'h000FFFE});
        end
        sync(); idle(); ack = 1;
        @(negedge clk);
        checks++;
        if (obs !== {32'h3000, 3'b110}) begin failures++; $display("FAIL beq_target got=%h exp=%h", obs, {32'h3000, 3'b110}); end
    endtask

    task automatic test_jal_pending();
        sync(); idle();
        br_valid_i = 1; br_taken_i = 1; br_kind_i = 1; br_pc4_i = 32'h3008; br_imm26_i = 26'h0000C40;
        @(negedge clk);
        checks++;
        if (obs !== {32'h3004, 3'b100}) begin failures++; $display("FAIL jal_wait1 got=%h exp=%h", obs, {32'h3004, 3'b100}); end
        sync(); idle();
        @(negedge clk);
        checks++;
        if (obs !== {32'h3004, 3'b100}) begin failures++; $display("FAIL jal_wait2 got=%h exp=%h", obs, {32'h3004, 3'b100}); end
        sync(); ack = 1;
        @(negedge clk);
        checks++;
        if (obs !== {32'h3004, 3'b110}) begin failures++; $display("FAIL jal_delay_slot got=%h exp=%h", obs, {32'h3004, 3'b110}); end
        sync(); ack = 1;
        @(negedge clk);
        checks++;
        if (obs !== {32'h3100, 3'b110}) begin failures++; $display("FAIL jal_target got=%h exp=%h", obs, {32'h3100, 3'b110}); end
    endtask

    task automatic test_stall_hold();
        sync(); ack = 1; stall_i = 1;
        @(negedge clk);
        checks++;
        if (obs !== {32'h3104, 3'b110}) begin failures++; $display("FAIL stall_ack got=%h exp=%h", obs, {32'h3104, 3'b110}); end
        for (int i = 0; i < 3; i++) begin
            sync(); ack = 0; stall_i = 1;
            @(negedge clk);
            checks++;
            if (obs !== {32'h3104, 3'b010}) begin failures++; $display("FAIL hold_%0d got=%h exp=%h", i, obs, {32'h3104, 3'b010}); end
        end
        sync(); stall_i = 0;
        @(negedge clk);
        checks++;
        if (obs !== {32'h3104, 3'b010}) begin failures++; $display("FAIL hold_release got=%h exp=%h", obs, {32'h3104, 3'b010}); end
        sync();
        @(negedge clk);
        checks++;
        if (obs !== {32'h3108, 3'b100}) begin failures++; $display("FAIL after_hold got=%h exp=%h", obs, {32'h3108, 3'b100}); end
    endtask

    task automatic test_exception_eret();
        sync(); exc_req_i = 1; ack = 0;
        @(negedge clk);
        checks++;
        if (obs !== {32'h3108, 3'b100}) begin failures++; $display("FAIL exc_squash got=%h exp=%h", obs, {32'h3108, 3'b100}); end
        sync(); exc_req_i = 0;
        @(negedge clk);
        checks++;
        if (obs !== {EXC_PC, 3'b000}) begin failures++; $display("FAIL exc_wait_drop got=%h exp=%h", obs, {EXC_PC, 3'b000}); end
        sync(); ack = 1;
        @(negedge clk);
        checks++;
        if (obs !== {EXC_PC, 3'b000}) begin failures++; $display("FAIL exc_late_ack got=%h exp=%h", obs, {EXC_PC, 3'b000}); end
        sync(); ack = 1;
        @(negedge clk);
        checks++;
        if (obs !== {EXC_PC, 3'b110}) begin failures++; $display("FAIL exc_vector got=%h exp=%h", obs, {EXC_PC, 3'b110}); end
        sync(); ack = 1; eret_req_i = 1; epc_i = 32'h300C;
        @(negedge clk);
        checks++;
        if (obs !== {32'h4184, 3'b100}) begin failures++; $display("FAIL eret_squash got=%h exp=%h", obs, {32'h4184, 3'b100}); end
        sync(); idle(); ack = 1;
        @(negedge clk);
        checks++;
        if (obs !== {32'h300C, 3'b110}) begin failures++; $display("FAIL eret_target got=%h exp=%h", obs, {32'h300C, 3'b110}); end
    endtask

    task automatic test_misaligned();
        sync(); ack = 1; jr_valid_i = 1; jr_target_i = 32'h3002;
        @(negedge clk);
        checks++;
        if (obs !== {32'h3010, 3'b110}) begin failures++; $display("FAIL jr_delay_slot got=%h exp=%h", obs, {32'h3010, 3'b110}); end
        sync(); idle();
        @(negedge clk);
        checks++;
        if (obs !== {32'h3002, 3'b011}) begin failures++; $display("FAIL adel got=%h exp=%h", obs, {32'h3002, 3'b011}); end
        sync(); jr_valid_i = 1; jr_target_i = 32'h3100;
        @(negedge clk);
        checks++;
        if (obs !== {32'h3006, 3'b011}) begin failures++; $display("FAIL adel_next got=%h exp=%h", obs, {32'h3006, 3'b011}); end
        sync(); idle(); ack = 1;
        @(negedge clk);
        checks++;
        if (obs !== {32'h3100, 3'b110}) begin failures++; $display("FAIL realign got=%h exp=%h", obs, {32'h3100, 3'b110}); end
    endtask

    task automatic test_async_reset();
        sync(); idle(); stall_i = 1;
        #2 reset = 0;
        #1;
        checks++;
        if (obs !== {RST_PC, 3'b000}) begin failures++; $display("FAIL async_reset got=%h exp=%h", obs, {RST_PC, 3'b000}); end
        sync(); reset = 1; stall_i = 1; ack = 1;
        @(negedge clk);
        checks++;
        if (obs !== {RST_PC, 3'b000}) begin failures++; $display("FAIL boot_after_async got=%h exp=%h", obs, {RST_PC, 3'b000}); end
        sync(); stall_i = 0; ack = 1;
        @(negedge clk);
        checks++;
        if (obs !== {RST_PC, 3'b110}) begin failures++; $display("FAIL boot_stall_ignored got=%h exp=%h", obs, {RST_PC, 3'b110}); end
    endtask

    task automatic rand_target(output logic [31:0] t);
        int sel = int'($urandom_range(0, 9));
        if (sel == 0)      t = 32'hFFFF_FFF8;                     // exercises wrap
        else if (sel == 1) t = {$urandom, 2'b00} | 32'(int'($urandom_range(1, 3)));
        else               t = {16'h0000, 14'($urandom), 2'b00};
    endtask

    // Behavioural model: a PC, whether a word is being held, whether an ack
    // owed to a squashed fetch is still to be dropped, and a one-deep queue
    // of deferred delay-slot targets.
    task automatic test_random();
        logic        m_boot, m_held, m_drop, mis, sq, word, has_tgt;
        logic [31:0] m_pc, tgt;
        logic [31:0] pend[$];
        logic [34:0] e_obs;
        sync(); idle(); reset = 0;
        @(negedge clk);
        sync(); reset = 1;
        m_boot = 1; m_held = 0; m_drop = 0; m_pc = RST_PC; pend.delete();
        for (int n = 0; n < 3000; n++) begin
            ack        = ($urandom_range(0, 99) < 60);
            stall_i    = ($urandom_range(0, 99) < 30);
            exc_req_i  = ($urandom_range(0, 99) < 3);
            eret_req_i = ($urandom_range(0, 99) < 3);
            jr_valid_i = ($urandom_range(0, 99) < 6);
            br_valid_i = ($urandom_range(0, 99) < 12);
            br_taken_i = 1'($urandom);
            br_kind_i  = 1'($urandom);
            br_pc4_i   = {16'h0000, 14'($urandom), 2'b00};
            br_imm26_i = 26'($urandom);
            rand_target(jr_target_i);
            rand_target(epc_i);

            mis  = (m_pc % 4) != 0;
            sq   = exc_req_i || eret_req_i;
            word = !m_boot && (m_held || (!m_drop && (mis || ack)));
            e_obs = {m_pc, !m_boot && !m_held && !m_drop && !mis, word && !sq, word && !sq && mis};
            has_tgt = 1;
            if (exc_req_i)                      tgt = EXC_PC;
            else if (eret_req_i)                tgt = epc_i;
            else if (jr_valid_i)                tgt = jr_target_i;
            else if (br_valid_i && br_taken_i)  tgt = npc_calc(br_kind_i, br_pc4_i, br_imm26_i);
            else begin has_tgt = 0; tgt = '0; end

            @(negedge clk);
            checks++;
            if (obs !== e_obs) begin failures++; $display("FAIL rand_obs cyc=%0d got=%h exp=%h", n, obs, e_obs); end
            checks++;
            if ({bus.pcex_op_o, bus.pcex_pc4_o, bus.pcex_imm26_o, bus.imem_addr_o} !== {br_kind_i, br_pc4_i, br_imm26_i, m_pc}) begin
                failures++; $display("FAIL rand_bus cyc=%0d got=%h exp=%h", n,
                    {bus.pcex_op_o, bus.pcex_pc4_o, bus.pcex_imm26_o, bus.imem_addr_o}, {br_kind_i, br_pc4_i, br_imm26_i, m_pc});
            end

            if (m_boot) begin
                m_boot = 0;
            end else if (sq) begin
                m_drop = !m_held && !ack && (m_drop || !mis);
                m_pc = tgt; pend.delete(); m_held = 0;
            end else begin
                if (m_drop && ack) m_drop = 0;
                if (word && !stall_i) begin
                    m_pc = has_tgt ? tgt : (pend.size() > 0 ? pend[0] : m_pc + 32'd4);
                    pend.delete(); m_held = 0;
                end else begin
                    if (has_tgt) begin pend.delete(); pend.push_back(tgt); end
                    if (word) m_held = 1;
                end
            end
            sync();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jal_pending();
        test_stall_hold();
        test_exception_eret();
        test_misaligned();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
